// File: rtl/tiled_matrix_mac.sv
// tiled_matrix_mac: output-stationary SIZE x SIZE outer-product MAC tile.
// Each accepted beat carries column k of A and row k of B. Every C[i][j] then
// accumulates a[i]*b[j], with all SIZE*SIZE products formed in the same cycle.
// Optional macro TILED_MATRIX_MAC_SATURATE_EN: clamp each accumulate on signed
// overflow. When the macro is undefined, accumulation wraps modulo 2^ACC_WIDTH.

// Per-element cell: signed product plus accumulate (or load), fully combinational.
module tiled_matrix_mac_pe #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 72
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic                  load,
  output logic [ACC_WIDTH-1:0]  acc_nxt
);
  localparam int PW = 2 * DATA_WIDTH;
  // One guard bit above the wider operand, so the raw sum never overflows.
  localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;

  logic signed [PW-1:0] a_x, b_x, prod;
  logic signed [SW-1:0] prod_x, acc_x, sum;

`ifdef TILED_MATRIX_MAC_SATURATE_EN
  localparam logic signed [SW-1:0] ONE  = 1;
  localparam logic signed [SW-1:0] MAXV = (ONE <<< (ACC_WIDTH - 1)) - ONE;
  localparam logic signed [SW-1:0] MINV = -(ONE <<< (ACC_WIDTH - 1));
`else
  logic unused_sum;
  assign unused_sum = ^sum;
`endif

  // Form the wide exact sum, then either clamp it or keep the low bits.
  always_comb begin
    a_x    = PW'($signed(a));
    b_x    = PW'($signed(b));
    prod   = a_x * b_x;
    prod_x = SW'(prod);
    acc_x  = load ? '0 : SW'($signed(acc));
    sum    = prod_x + acc_x;
`ifdef TILED_MATRIX_MAC_SATURATE_EN
    if (sum > MAXV)      acc_nxt = MAXV[ACC_WIDTH-1:0];
    else if (sum < MINV) acc_nxt = MINV[ACC_WIDTH-1:0];
    else                 acc_nxt = sum[ACC_WIDTH-1:0];
`else
    acc_nxt = sum[ACC_WIDTH-1:0];
`endif
  end
endmodule

module tiled_matrix_mac #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 4,
  parameter int MAX_BEATS  = 256,
  parameter int ACC_WIDTH  = 72
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_last,
  input  logic [DATA_WIDTH*SIZE-1:0]          a_col,
  input  logic [DATA_WIDTH*SIZE-1:0]          b_row,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ACC_WIDTH*SIZE*SIZE-1:0]      c_out,
  output logic [$clog2(MAX_BEATS+1)-1:0]      beat_cnt,
  output logic                                k_overflow
);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam int NE = SIZE * SIZE;

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_e;

  state_e                         state_q, state_d;
  logic [CW-1:0]                  beat_cnt_q, beat_cnt_d;
  logic                           k_overflow_q, k_overflow_d;
  logic                           out_valid_q, out_valid_d;
  logic                           in_ready_q, in_ready_d;
  logic [NE-1:0][ACC_WIDTH-1:0]   acc_q, acc_d, acc_nxt;
  logic [SIZE-1:0][DATA_WIDTH-1:0] a_v, b_v;
  logic                           accept, load;

  assign a_v    = a_col;
  assign b_v    = b_row;
  // clr discards a beat presented in the same cycle.
  assign accept = in_valid & in_ready_q & ~clr;
  assign load   = (state_q == IDLE);

  for (genvar i = 0; i < SIZE; i++) begin : g_row
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      tiled_matrix_mac_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .a(a_v[i]), .b(b_v[j]), .acc(acc_q[SIZE*i+j]), .load(load),
        .acc_nxt(acc_nxt[SIZE*i+j])
      );
    end
  end

  // Next-state logic for the control FSM and its registered outputs.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    k_overflow_d = k_overflow_q;
    out_valid_d  = out_valid_q;
    in_ready_d   = in_ready_q;
    acc_d        = accept ? acc_nxt : acc_q;
    if (clr) begin
      state_d      = IDLE;
      beat_cnt_d   = '0;
      k_overflow_d = 1'b0;
      out_valid_d  = 1'b0;
      in_ready_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE, ACCUM: if (accept) begin
          beat_cnt_d = (state_q == IDLE) ? CW'(1) : beat_cnt_q + CW'(1);
          if (in_last || beat_cnt_d == CW'(MAX_BEATS)) begin
            state_d      = OUT;
            k_overflow_d = ~in_last;
            out_valid_d  = 1'b1;
            in_ready_d   = 1'b0;
          end else begin
            state_d = ACCUM;
          end
        end
        OUT: if (out_ready) begin
          state_d      = IDLE;
          k_overflow_d = 1'b0;
          out_valid_d  = 1'b0;
          in_ready_d   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and handshake/status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      k_overflow_q <= 1'b0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      k_overflow_q <= k_overflow_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Accumulator tile; doubles as the held c_out while in OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign c_out      = acc_q;
  assign beat_cnt   = beat_cnt_q;
  assign k_overflow = k_overflow_q;
  assign out_valid  = out_valid_q;
  assign in_ready   = in_ready_q;
endmodule

// File: tb/tb_tiled_matrix_mac.sv
// Bench for tiled_matrix_mac: directed corner cases plus random tiles,
// all checked against an arithmetic model of the C = A*B tile.
module tb_tiled_matrix_mac;
  localparam int DW = 8;
  localparam int SZ = 4;
  localparam int MB = 6;
  localparam int AW = 16;
  localparam int CW = $clog2(MB + 1);

  logic                 clk, rst_n, clr, in_valid, in_ready, in_last;
  logic [DW*SZ-1:0]     a_col, b_row;
  logic                 out_valid, out_ready, k_overflow;
  logic [AW*SZ*SZ-1:0]  c_out;
  logic [CW-1:0]        beat_cnt;

  tiled_matrix_mac #(.DATA_WIDTH(DW), .SIZE(SZ), .MAX_BEATS(MB), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .a_col(a_col), .b_row(b_row), .out_valid(out_valid),
    .out_ready(out_ready), .c_out(c_out), .beat_cnt(beat_cnt), .k_overflow(k_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: exact matrix values, tile bookkeeping as plain flags.
  longint m[SZ][SZ];
  int     m_cnt;
  bit     m_kov, m_tile, m_out;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint fit(input longint v);
    longint lim, r;
    lim = longint'(1) << (AW - 1);
`ifdef TILED_MATRIX_MAC_SATURATE_EN
    if (v > lim - 1) r = lim - 1;
    else if (v < -lim) r = -lim;
    else r = v;
`else
    r = v & ((lim << 1) - 1);
    if (r >= lim) r = r - (lim << 1);
`endif
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SZ; i++) for (int j = 0; j < SZ; j++) m[i][j] = 0;
    m_cnt = 0; m_kov = 0; m_tile = 0; m_out = 0;
  endtask

  task automatic model_beat(input logic [DW*SZ-1:0] a, input logic [DW*SZ-1:0] b, input bit last);
    longint ai, bj;
    logic [DW-1:0] ea, eb;
    if (!m_tile) begin
      for (int i = 0; i < SZ; i++) for (int j = 0; j < SZ; j++) m[i][j] = 0;
      m_cnt = 0;
    end
    for (int i = 0; i < SZ; i++) begin
      ea = a[DW*i +: DW];
      ai = longint'($signed(ea));
      for (int j = 0; j < SZ; j++) begin
        eb = b[DW*j +: DW];
        bj = longint'($signed(eb));
        m[i][j] = fit(m[i][j] + ai * bj);
      end
    end
    m_cnt++;
    m_tile = 1;
    if (last) m_out = 1;
    else if (m_cnt == MB) begin m_out = 1; m_kov = 1; end
  endtask

  task automatic check_all(input string tag);
    logic [255:0] e;
    longint t;
    e = '0;
    for (int i = 0; i < SZ; i++) for (int j = 0; j < SZ; j++) begin
      t = m[i][j];
      e[AW*(SZ*i+j) +: AW] = t[AW-1:0];
    end
    chk({tag, ".out_valid"}, out_valid, m_out);
    chk({tag, ".in_ready"}, in_ready, !m_out);
    chk({tag, ".beat_cnt"}, beat_cnt, m_cnt);
    chk({tag, ".k_overflow"}, k_overflow, m_kov);
    chk({tag, ".c_out"}, c_out, e);
  endtask

  // Present one beat at a negedge; the following posedge accepts it.
  task automatic beat(input logic [DW*SZ-1:0] a, input logic [DW*SZ-1:0] b, input bit last);
    a_col = a; b_row = b; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    model_beat(a, b, last);
  endtask

  // Hold out_ready low with junk inputs (must be ignored), then hand off.
  task automatic drain(input int hold);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1)); in_last = 1'($urandom_range(0, 1));
      a_col = $urandom; b_row = $urandom;
      @(negedge clk);
      check_all("hold");
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    m_out = 0; m_tile = 0; m_kov = 0;
    check_all("drain");
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    a_col = '0; b_row = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("reset");

    // Single-beat tile: C[i][j] = (i+1)*(j+5).
    beat(32'h04030201, 32'h08070605, 1'b1);
    check_all("one_beat");
    drain(2);

    // Identity A times random B: result equals B, held through backpressure.
    for (int k = 0; k < SZ; k++) begin
      logic [DW*SZ-1:0] e_k;
      e_k = '0;
      e_k[DW*k +: DW] = 8'd1;
      beat(e_k, $urandom, k == SZ - 1);
    end
    check_all("ident");
    drain(5);

    // Force-close at MAX_BEATS without in_last.
    for (int k = 0; k < MB; k++) beat(32'h01010101, 32'h01010101, 1'b0);
    check_all("kovf");
    drain(1);

    // Two beats of (-128)*(-128): overflows the accumulator width.
    beat(32'h80808080, 32'h80808080, 1'b0);
    beat(32'h80808080, 32'h80808080, 1'b1);
    check_all("wrap");
    drain(0);

    // clr with a valid beat in the second cycle of a 3-beat tile.
    beat($urandom, $urandom, 1'b0);
    check_all("pre_clr");
    clr = 1'b1; in_valid = 1'b1; a_col = $urandom; b_row = $urandom;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    m_tile = 0; m_out = 0; m_cnt = 0; m_kov = 0;
    check_all("clr");
    beat(32'h02020202, 32'h02020202, 1'b1);
    check_all("post_clr");
    drain(1);

    // Asynchronous reset mid-tile, in ACCUM and in OUT.
    for (int s = 0; s < 2; s++) begin
      beat($urandom, $urandom, s == 1);
      #1 rst_n = 1'b0;
      #2;
      chk("rst_async.out_valid", out_valid, 1'b0);
      chk("rst_async.c_out", c_out, '0);
      rst_n = 1'b1;
      @(negedge clk);
      model_reset();
      check_all("rst_after");
      beat(32'h01020304, 32'h05060708, 1'b1);
      check_all("rst_fresh");
      drain(1);
    end

    // Random tiles with idle gaps; long tiles close on overflow.
    for (int t = 0; t < 30; t++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int k = 0; k < len && !m_out; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0; a_col = $urandom; b_row = $urandom; in_last = 1'($urandom_range(0, 1));
          @(negedge clk);
          in_last = 1'b0;
          check_all("gap");
        end
        beat($urandom, $urandom, k == len - 1);
        check_all("rnd");
      end
      drain($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
